// File: rtl/timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : timer_pkg                                                   |
// | Description : Shared definitions for the interval timer peripheral:       |
// |               register byte offsets, CTRL bit positions, the packed CTRL  |
// |               register type and a helper that unpacks a bus write word.   |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package timer_pkg;

  // Register byte offsets from the peripheral base address
  localparam logic [31:0] TIMER_CTRL     = 32'h00;
  localparam logic [31:0] TIMER_PRESCALE = 32'h04;
  localparam logic [31:0] TIMER_RELOAD   = 32'h08;
  localparam logic [31:0] TIMER_COUNT    = 32'h0C;
  localparam logic [31:0] TIMER_STATUS   = 32'h10;

  // CTRL register bit positions
  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_ENABLE_BIT  = 2;

  // Field order puts enable at bit 0, matching the register layout
  typedef struct packed {
    logic irq_enable;
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

  function automatic timer_ctrl_t ctrl_from_word(input logic [31:0] word);
    timer_ctrl_t c;
    c.enable      = word[CTRL_ENABLE_BIT];
    c.auto_reload = word[CTRL_AUTO_RELOAD_BIT];
    c.irq_enable  = word[CTRL_IRQ_ENABLE_BIT];
    return c;
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/interval_timer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : interval_timer_if                                           |
// | Description : Nyuzi IO bus as seen by a memory-mapped peripheral.         |
// |   io_write_en   : write strobe, one cycle per write                       |
// |   io_read_en    : read strobe                                             |
// |   io_address    : byte address                                            |
// |   io_write_data : write data                                              |
// |   io_read_data  : registered read data from the peripheral                |
// |   master drives the request side, slave returns io_read_data.             |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface interval_timer_if;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (
    output io_write_en,
    output io_read_en,
    output io_address,
    output io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_write_en,
    input  io_read_en,
    input  io_address,
    input  io_write_data,
    output io_read_data
  );
endinterface : interval_timer_if
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer_prescaler                                             |
// | Description : Enable-gated up counter compared against a divisor; emits  |
// |               a one-cycle tick every (divisor+1) enabled cycles.          |
// |   clk, reset : clock, asynchronous active-high reset                     |
// |   enable     : counting enable; when low the count is held at 0          |
// |   restart    : synchronous restart of the count from 0                   |
// |   divisor    : compare value (divide ratio minus one)                    |
// |   tick       : high in the cycle the count equals divisor                |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      enable,
  input  wire logic                      restart,
  input  wire logic [PRESCALE_WIDTH-1:0] divisor,
  output logic                           tick
);

  logic [PRESCALE_WIDTH-1:0] prescale_count;

  // Equality compare only: if the divisor is lowered below the running
  // count, the count free-runs through its natural wrap back to 0.
  assign tick = enable & (prescale_count == divisor);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_count <= '0;
    end else if (!enable || restart || tick) begin
      prescale_count <= '0;
    end else begin
      prescale_count <= prescale_count + PRESCALE_WIDTH'(1);
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : interval_timer                                              |
// | Description : Programmable down-counting timer on the Nyuzi IO bus with  |
// |               one-shot / auto-reload modes, a prescaler and a level       |
// |               interrupt.                                                  |
// |   clk, reset      : clock, asynchronous active-high reset                |
// |   bus (slave)     : IO bus; registers at BASE_ADDRESS + 0,4,8,C,10       |
// |   timer_interrupt : registered level interrupt (pending & irq_enable)    |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module interval_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h60,
  parameter int          PRESCALE_WIDTH = 16,
  parameter int          COUNTER_WIDTH  = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  interval_timer_if.slave  bus,
  output logic             timer_interrupt
);

  timer_ctrl_t               ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [COUNTER_WIDTH-1:0]  reload;
  logic [COUNTER_WIDTH-1:0]  count;
  logic                      pending;
  logic                      tick;

  // Exact full-width decode: unaligned or partial matches are unmapped
  logic sel_ctrl, sel_prescale, sel_reload, sel_count, sel_status;
  assign sel_ctrl     = (bus.io_address == BASE_ADDRESS + TIMER_CTRL);
  assign sel_prescale = (bus.io_address == BASE_ADDRESS + TIMER_PRESCALE);
  assign sel_reload   = (bus.io_address == BASE_ADDRESS + TIMER_RELOAD);
  assign sel_count    = (bus.io_address == BASE_ADDRESS + TIMER_COUNT);
  assign sel_status   = (bus.io_address == BASE_ADDRESS + TIMER_STATUS);

  logic wr_ctrl, wr_prescale, wr_reload, clear_pending;
  assign wr_ctrl       = bus.io_write_en & sel_ctrl;
  assign wr_prescale   = bus.io_write_en & sel_prescale;
  assign wr_reload     = bus.io_write_en & sel_reload;
  assign clear_pending = bus.io_write_en & sel_status & bus.io_write_data[0];

  // Reads are driven purely by address; the strobe and the upper write bits
  // (when the registers are narrower than the bus) are not needed.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.io_read_en, bus.io_write_data};

  // A RELOAD write in the same cycle as a tick takes priority, so the tick
  // neither decrements nor expires.
  logic expire;
  assign expire = tick & ~wr_reload & (count == '0);

  timer_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (ctrl.enable),
    .restart (wr_reload),
    .divisor (prescale),
    .tick    (tick)
  );

  // CTRL: a software write overrides the one-shot hardware clear of enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= ctrl_from_word(bus.io_write_data);
    end else if (expire && !ctrl.auto_reload) begin
      ctrl.enable <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      reload   <= '0;
    end else begin
      if (wr_prescale) prescale <= bus.io_write_data[PRESCALE_WIDTH-1:0];
      if (wr_reload)   reload   <= bus.io_write_data[COUNTER_WIDTH-1:0];
    end
  end

  // Down counter: expiry happens on the tick that finds count already at 0,
  // giving a period of (RELOAD+1) ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_reload) begin
      count <= bus.io_write_data[COUNTER_WIDTH-1:0];
    end else if (tick) begin
      if (count != '0) begin
        count <= count - COUNTER_WIDTH'(1);
      end else if (ctrl.auto_reload) begin
        count <= reload;
      end
    end
  end

  // Setting wins over a simultaneous software clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (expire) begin
      pending <= 1'b1;
    end else if (clear_pending) begin
      pending <= 1'b0;
    end
  end

  // Interrupt follows the registered pending/irq_enable, so it rises the
  // cycle after pending sets and falls the cycle after it clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= pending & ctrl.irq_enable;
    end
  end

  logic [31:0] read_mux;
  always_comb begin
    read_mux = 32'h0;
    if (sel_ctrl)          read_mux = {29'h0, ctrl};
    else if (sel_prescale) read_mux = 32'(prescale);
    else if (sel_reload)   read_mux = 32'(reload);
    else if (sel_count)    read_mux = 32'(count);
    else if (sel_status)   read_mux = {31'h0, pending};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.io_read_data <= 32'h0;
    end else begin
      bus.io_read_data <= read_mux;
    end
  end

endmodule : interval_timer
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_interval_timer                                           |
// | Description : Self-checking bench for interval_timer: a vector table for  |
// |               the auto-reload flow plus directed sequences for one-shot, |
// |               clear/expire collisions, reload-on-tick, decode and reset.  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_interval_timer;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h60;
  localparam int OP_IDLE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;
  localparam int NVEC    = 19;

  logic clk;
  logic reset;
  logic timer_interrupt;
  interval_timer_if bus_if ();

  interval_timer #(
    .BASE_ADDRESS   (BASE),
    .PRESCALE_WIDTH (16),
    .COUNTER_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus_if),
    .timer_interrupt (timer_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] off;
    logic [31:0] data;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [31:0] rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'h0, timer_interrupt}, {31'h0, exp});
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    bus_if.io_write_en   = 1'b1;
    bus_if.io_address    = BASE + off;
    bus_if.io_write_data = d;
    @(posedge clk);
    #1;
    bus_if.io_write_en = 1'b0;
  endtask

  task automatic rd_abs(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk);
    bus_if.io_read_en  = 1'b1;
    bus_if.io_address  = addr;
    @(posedge clk);
    #1;
    d = bus_if.io_read_data;
    bus_if.io_read_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    rd_abs(BASE + off, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    check(name, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Auto-reload flow, PRESCALE=0, RELOAD=4: expiry every 5 cycles
    vecs[0]  = '{OP_WR, TIMER_PRESCALE, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[1]  = '{OP_WR, TIMER_RELOAD,   32'd4, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[2]  = '{OP_WR, TIMER_CTRL,     32'd7, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[3]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd4, 1'b1, 1'b0};
    vecs[4]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd3, 1'b1, 1'b0};
    vecs[5]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd2, 1'b1, 1'b0};
    vecs[6]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd1, 1'b1, 1'b0};
    vecs[7]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[8]  = '{OP_RD, TIMER_STATUS,   32'd0, 1'b1, 32'd1, 1'b1, 1'b1};
    vecs[9]  = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd3, 1'b1, 1'b1};
    vecs[10] = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd2, 1'b1, 1'b1};
    vecs[11] = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd1, 1'b1, 1'b1};
    vecs[12] = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd0, 1'b1, 1'b1};
    vecs[13] = '{OP_RD, TIMER_CTRL,     32'd0, 1'b1, 32'd7, 1'b1, 1'b1};
    vecs[14] = '{OP_WR, TIMER_STATUS,   32'd1, 1'b0, 32'd0, 1'b0, 1'b0};
    vecs[15] = '{OP_RD, TIMER_STATUS,   32'd0, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[16] = '{OP_WR, TIMER_CTRL,     32'd0, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[17] = '{OP_RD, TIMER_STATUS,   32'd0, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[18] = '{OP_RD, TIMER_COUNT,    32'd0, 1'b1, 32'd0, 1'b1, 1'b0};

    reset                = 1'b1;
    bus_if.io_write_en   = 1'b0;
    bus_if.io_read_en    = 1'b0;
    bus_if.io_address    = 32'h0;
    bus_if.io_write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset read_data", bus_if.io_read_data, 32'h0);
    check_irq("reset irq", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    rd_check("reset CTRL", TIMER_CTRL, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      case (vecs[i].op)
        OP_WR:   wr(vecs[i].off, vecs[i].data);
        OP_RD:   rd(vecs[i].off, rdata);
        default: idle(1);
      endcase
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d read", i), rdata, vecs[i].exp_rd);
      if (vecs[i].chk_irq)
        check_irq($sformatf("vec%0d irq", i), vecs[i].exp_irq);
    end

    // One-shot: PRESCALE=3, RELOAD=2 -> pending 12 cycles after enable
    wr(TIMER_PRESCALE, 32'd3);
    wr(TIMER_RELOAD, 32'd2);
    wr(TIMER_CTRL, 32'd5);
    idle(11);
    rd_check("oneshot status before", TIMER_STATUS, 32'd0);
    check_irq("oneshot irq before", 1'b0);
    rd_check("oneshot status set", TIMER_STATUS, 32'd1);
    check_irq("oneshot irq set", 1'b1);
    rd_check("oneshot ctrl cleared", TIMER_CTRL, 32'd4);
    rd_check("oneshot count zero", TIMER_COUNT, 32'd0);
    idle(20);
    rd_check("oneshot count held", TIMER_COUNT, 32'd0);
    wr(TIMER_STATUS, 32'd1);
    idle(1);
    check_irq("oneshot irq cleared", 1'b0);
    rd_check("oneshot no re-expire", TIMER_STATUS, 32'd0);

    // Expire and clear collide; irq gated off, then enabled
    wr(TIMER_PRESCALE, 32'd0);
    wr(TIMER_RELOAD, 32'd2);
    wr(TIMER_CTRL, 32'd3);
    idle(2);
    wr(TIMER_STATUS, 32'd1);
    rd_check("collide status kept", TIMER_STATUS, 32'd1);
    check_irq("irq disabled", 1'b0);
    wr(TIMER_CTRL, 32'd7);
    check_irq("irq enable same edge", 1'b0);
    idle(1);
    check_irq("irq enable next", 1'b1);
    wr(TIMER_STATUS, 32'd1);
    wr(TIMER_CTRL, 32'd0);
    check_irq("irq after clear", 1'b0);
    rd_check("status after clear", TIMER_STATUS, 32'd0);

    // RELOAD write landing on a tick with count=7
    wr(TIMER_PRESCALE, 32'd1);
    wr(TIMER_RELOAD, 32'd8);
    wr(TIMER_CTRL, 32'd1);
    idle(2);
    rd_check("reload count7", TIMER_COUNT, 32'd7);
    wr(TIMER_RELOAD, 32'd100);
    rd_check("reload new value", TIMER_COUNT, 32'd100);
    rd_check("reload no early dec", TIMER_COUNT, 32'd100);
    rd_check("reload first dec", TIMER_COUNT, 32'd99);
    rd_check("reload no expire", TIMER_STATUS, 32'd0);
    wr(TIMER_CTRL, 32'd0);

    // COUNT is read-only; decode is exact
    wr(TIMER_COUNT, 32'd55);
    rd_check("count write ignored", TIMER_COUNT, 32'd98);
    wr(TIMER_CTRL, 32'd6);
    rd_check("ctrl readback", TIMER_CTRL, 32'd6);
    rd_abs(BASE + 32'h2, rdata);
    check("unaligned read", rdata, 32'h0);
    rd_abs(BASE + 32'h14, rdata);
    check("past-end read", rdata, 32'h0);
    rd_check("prescale readback", TIMER_PRESCALE, 32'd1);
    rd_check("reload readback", TIMER_RELOAD, 32'd100);

    // Reset mid-count with interrupt asserted
    wr(TIMER_PRESCALE, 32'd0);
    wr(TIMER_RELOAD, 32'd0);
    wr(TIMER_CTRL, 32'd7);
    idle(2);
    check_irq("pre-reset irq", 1'b1);
    wr(TIMER_RELOAD, 32'd50);
    idle(30);
    rd_check("pre-reset count", TIMER_COUNT, 32'd20);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_irq("async reset irq", 1'b0);
    check("async reset read_data", bus_if.io_read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd_check("post-reset CTRL", TIMER_CTRL, 32'h0);
    rd_check("post-reset PRESCALE", TIMER_PRESCALE, 32'h0);
    rd_check("post-reset RELOAD", TIMER_RELOAD, 32'h0);
    rd_check("post-reset COUNT", TIMER_COUNT, 32'h0);
    rd_check("post-reset STATUS", TIMER_STATUS, 32'h0);
    idle(10);
    rd_check("idle after reset count", TIMER_COUNT, 32'h0);
    rd_check("idle after reset status", TIMER_STATUS, 32'h0);
    check_irq("idle after reset irq", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_interval_timer
`default_nettype wire
